// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes the instruction into ALU controls, registers it into EX,
// and drives the ALU operands through the immediate and forwarding muxes. Also detects load-use hazards.
module id_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        fwd_mem_we,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_mem_data,
    input  logic        fwd_wb_we,
    input  logic [4:0]  fwd_wb_rd,
    input  logic [31:0] fwd_wb_data,
    output logic        hazard,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_illegal,
    output logic [4:0]  ex_dst,
    output logic [31:0] ex_store_data
);
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0010, OP_SLT = 4'b1010,
                           OP_AND = 4'b0100, OP_OR = 4'b0101, OP_XOR = 4'b0110,
                           OP_NOR = 4'b0111;

    logic [5:0]  opcode, funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] imm;
    assign opcode = id_instr[31:26];
    assign id_rs  = id_instr[25:21];
    assign id_rt  = id_instr[20:16];
    assign id_rd  = id_instr[15:11];
    assign imm    = id_instr[15:0];
    assign funct  = id_instr[5:0];

    logic [3:0]  d_op;
    logic [4:0]  d_dst;
    logic        d_rw, d_mr, d_mw, d_br, d_ill, d_use_imm, d_sext, uses_rt;
    logic [31:0] d_imm;

    always_comb begin
        d_op      = OP_ADD;
        d_dst     = id_rt;
        d_rw      = 1'b0;
        d_mr      = 1'b0;
        d_mw      = 1'b0;
        d_br      = 1'b0;
        d_ill     = 1'b0;
        d_use_imm = 1'b1;
        d_sext    = 1'b1;
        uses_rt   = 1'b0;
        case (opcode)
            6'h00: begin
                uses_rt   = 1'b1;
                d_use_imm = 1'b0;
                d_dst     = id_rd;
                d_rw      = 1'b1;
                case (funct)
                    6'h20, 6'h21: d_op = OP_ADD;
                    6'h22, 6'h23: d_op = OP_SUB;
                    6'h24:        d_op = OP_AND;
                    6'h25:        d_op = OP_OR;
                    6'h26:        d_op = OP_XOR;
                    6'h27:        d_op = OP_NOR;
                    6'h2A:        d_op = OP_SLT;
                    default:      d_ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: d_rw = 1'b1;
            6'h0A: begin d_op = OP_SLT; d_rw = 1'b1; end
            6'h0C: begin d_op = OP_AND; d_rw = 1'b1; d_sext = 1'b0; end
            6'h0D: begin d_op = OP_OR;  d_rw = 1'b1; d_sext = 1'b0; end
            6'h0E: begin d_op = OP_XOR; d_rw = 1'b1; d_sext = 1'b0; end
            6'h23: begin d_mr = 1'b1; d_rw = 1'b1; end
            6'h2B: begin d_mw = 1'b1; uses_rt = 1'b1; end
            6'h04: begin d_op = OP_SUB; d_br = 1'b1; d_use_imm = 1'b0; uses_rt = 1'b1; end
            default: d_ill = 1'b1;
        endcase
        // Illegal instructions carry no side effects into EX, only the trap flag.
        if (d_ill) begin
            d_op  = OP_ADD;
            d_dst = 5'd0;
            d_rw  = 1'b0;
            d_mr  = 1'b0;
            d_mw  = 1'b0;
            d_br  = 1'b0;
        end
        if (d_dst == 5'd0) d_rw = 1'b0;
    end

    assign d_imm = d_sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};

    logic        ex_use_imm;
    logic [4:0]  ex_rs, ex_rt;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;

    assign hazard = ex_valid & ex_mem_read & id_valid & (ex_dst != 5'd0) &
                    ((ex_dst == id_rs) | (uses_rt & (ex_dst == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            alu_op       <= OP_ADD;
            ex_dst       <= 5'd0;
        end else if (flush || (!stall && (hazard || !id_valid))) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            alu_op       <= OP_ADD;
            ex_dst       <= 5'd0;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            ex_reg_write <= d_rw;
            ex_mem_read  <= d_mr;
            ex_mem_write <= d_mw;
            ex_branch    <= d_br;
            ex_illegal   <= d_ill;
            alu_op       <= d_op;
            ex_dst       <= d_dst;
        end
    end

    // Operand data is don't-care in a bubble, so it only needs to honour stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_use_imm <= 1'b0;
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rs_data <= 32'd0;
            ex_rt_data <= 32'd0;
            ex_imm     <= 32'd0;
        end else if (!stall && !flush) begin
            ex_use_imm <= d_use_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= d_imm;
        end
    end

    logic [31:0] rs_val, rt_val;

    always_comb begin
        rs_val = ex_rs_data;
        if (FWD_EN && ex_rs != 5'd0) begin
            if (fwd_mem_we && fwd_mem_rd == ex_rs)     rs_val = fwd_mem_data;
            else if (fwd_wb_we && fwd_wb_rd == ex_rs)  rs_val = fwd_wb_data;
        end
    end

    always_comb begin
        rt_val = ex_rt_data;
        if (FWD_EN && ex_rt != 5'd0) begin
            if (fwd_mem_we && fwd_mem_rd == ex_rt)     rt_val = fwd_mem_data;
            else if (fwd_wb_we && fwd_wb_rd == ex_rt)  rt_val = fwd_wb_data;
        end
    end

    assign alu_a         = rs_val;
    assign alu_b         = ex_use_imm ? ex_imm : rt_val;
    assign ex_store_data = rt_val;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a vector table through a scoreboard queue, then hand-written
// sequences for load-use, stall, flush and reset.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr, id_rs_data, id_rt_data;
    logic        stall, flush;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        hazard;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
    logic [4:0]  ex_dst;

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .hazard(hazard), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal),
        .ex_dst(ex_dst), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, rs_d, rt_d;
        logic        mwe, wwe;
        logic [4:0]  mrd, wrd;
        logic [31:0] mdat, wdat;
        logic [3:0]  op;
        logic [31:0] a, b, st;
        logic [4:0]  dst;
        logic [4:0]  ctl;   // {reg_write, mem_read, mem_write, branch, illegal}
        logic        chk_ab, chk_dst;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   nvec = 0;
    int   nfail = 0;

    function automatic logic [31:0] rt_i(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] st, input logic [4:0] dst,
                                input logic [4:0] ctl);
        vec_t t;
        t.instr = instr; t.rs_d = rsd; t.rt_d = rtd;
        t.mwe = 1'b0; t.wwe = 1'b0; t.mrd = 5'd0; t.wrd = 5'd0;
        t.mdat = 32'd0; t.wdat = 32'd0;
        t.op = op; t.a = a; t.b = b; t.st = st; t.dst = dst; t.ctl = ctl;
        t.chk_ab = !ctl[0];
        t.chk_dst = !ctl[0];
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_fwd();
        fwd_mem_we = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
        fwd_wb_we  = 1'b0; fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'd0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1'b1; id_instr = instr; id_rs_data = rsd; id_rt_data = rtd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        drive(t.instr, t.rs_d, t.rt_d);
        exp_q.push_back(t);
        #1 chk($sformatf("v%0d hazard", idx), {31'd0, hazard}, 32'd0);
        step();
        e = exp_q.pop_front();
        fwd_mem_we = e.mwe; fwd_mem_rd = e.mrd; fwd_mem_data = e.mdat;
        fwd_wb_we  = e.wwe; fwd_wb_rd  = e.wrd; fwd_wb_data  = e.wdat;
        #1;
        chk($sformatf("v%0d valid", idx), {31'd0, ex_valid}, 32'd1);
        chk($sformatf("v%0d alu_op", idx), {28'd0, alu_op}, {28'd0, e.op});
        chk($sformatf("v%0d ctl", idx),
            {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal},
            {27'd0, e.ctl});
        if (e.chk_dst) chk($sformatf("v%0d dst", idx), {27'd0, ex_dst}, {27'd0, e.dst});
        if (e.chk_ab) begin
            chk($sformatf("v%0d alu_a", idx), alu_a, e.a);
            chk($sformatf("v%0d alu_b", idx), alu_b, e.b);
            chk($sformatf("v%0d store", idx), ex_store_data, e.st);
        end
        clear_fwd();
    endtask

    initial begin
        vec_t t;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_instr = 32'd0; id_rs_data = 32'd0; id_rt_data = 32'd0;
        clear_fwd();

        vecs.push_back(mk(rt_i(1, 2, 3, 6'h20), 5, 7, 4'b0000, 5, 7, 7, 3, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 3, 6'h22), 10, 3, 4'b0010, 10, 3, 3, 3, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 6, 6'h24), 32'hF0F0, 32'hFF00, 4'b0100, 32'hF0F0, 32'hFF00, 32'hFF00, 6, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 6, 6'h25), 1, 2, 4'b0101, 1, 2, 2, 6, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 6, 6'h26), 1, 2, 4'b0110, 1, 2, 2, 6, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 6, 6'h27), 1, 2, 4'b0111, 1, 2, 2, 6, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 6, 6'h2A), 1, 2, 4'b1010, 1, 2, 2, 6, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 6, 6'h21), 1, 2, 4'b0000, 1, 2, 2, 6, 5'b10000));
        vecs.push_back(mk(rt_i(1, 2, 6, 6'h23), 1, 2, 4'b0010, 1, 2, 2, 6, 5'b10000));
        vecs.push_back(mk(it_i(6'h0C, 1, 4, 16'hFFFF), 9, 32'h1234, 4'b0100, 9, 32'h0000FFFF, 32'h1234, 4, 5'b10000));
        vecs.push_back(mk(it_i(6'h0A, 1, 5, 16'hFFFF), 3, 0, 4'b1010, 3, 32'hFFFFFFFF, 0, 5, 5'b10000));
        vecs.push_back(mk(it_i(6'h0D, 2, 6, 16'h8000), 1, 0, 4'b0101, 1, 32'h00008000, 0, 6, 5'b10000));
        vecs.push_back(mk(it_i(6'h0E, 2, 6, 16'h0001), 1, 0, 4'b0110, 1, 1, 0, 6, 5'b10000));
        vecs.push_back(mk(it_i(6'h08, 2, 6, 16'h8000), 1, 0, 4'b0000, 1, 32'hFFFF8000, 0, 6, 5'b10000));
        vecs.push_back(mk(it_i(6'h09, 2, 6, 16'h0007), 1, 0, 4'b0000, 1, 7, 0, 6, 5'b10000));
        t = mk(it_i(6'h2B, 1, 6, 16'h0004), 32'h100, 32'hAB, 4'b0000, 32'h100, 4, 32'hAB, 0, 5'b00100);
        t.chk_dst = 1'b0; vecs.push_back(t);
        t = mk(it_i(6'h04, 1, 2, 16'h0010), 8, 8, 4'b0010, 8, 8, 8, 0, 5'b00010);
        t.chk_dst = 1'b0; vecs.push_back(t);
        vecs.push_back(mk(it_i(6'h23, 1, 0, 16'h0008), 32'h40, 0, 4'b0000, 32'h40, 8, 0, 0, 5'b01000));
        vecs.push_back(mk(rt_i(1, 2, 0, 6'h20), 1, 2, 4'b0000, 1, 2, 2, 0, 5'b00000));
        vecs.push_back(mk(it_i(6'h3F, 1, 2, 16'h0000), 1, 2, 4'b0000, 0, 0, 0, 0, 5'b00001));
        vecs.push_back(mk(rt_i(1, 2, 3, 6'h00), 1, 2, 4'b0000, 0, 0, 0, 0, 5'b00001));
        t = mk(rt_i(3, 0, 7, 6'h20), 32'h99, 32'h55, 4'b0000, 32'h11, 32'h55, 32'h55, 7, 5'b10000);
        t.mwe = 1; t.mrd = 3; t.mdat = 32'h11; t.wwe = 1; t.wrd = 3; t.wdat = 32'h22; vecs.push_back(t);
        t = mk(rt_i(3, 0, 7, 6'h20), 32'h99, 32'h55, 4'b0000, 32'h22, 32'h55, 32'h55, 7, 5'b10000);
        t.mwe = 1; t.mrd = 9; t.mdat = 32'h11; t.wwe = 1; t.wrd = 3; t.wdat = 32'h22; vecs.push_back(t);
        t = mk(rt_i(3, 0, 7, 6'h20), 32'h99, 32'h55, 4'b0000, 32'h99, 32'h55, 32'h55, 7, 5'b10000);
        t.mwe = 0; t.mrd = 3; t.mdat = 32'h11; t.wwe = 0; t.wrd = 3; t.wdat = 32'h22; vecs.push_back(t);
        t = mk(rt_i(0, 3, 7, 6'h20), 32'h99, 32'h55, 4'b0000, 32'h99, 32'h22, 32'h22, 7, 5'b10000);
        t.mwe = 1; t.mrd = 0; t.mdat = 32'h11; t.wwe = 1; t.wrd = 3; t.wdat = 32'h22; vecs.push_back(t);
        t = mk(it_i(6'h2B, 1, 6, 16'h0004), 32'h100, 32'hAB, 4'b0000, 32'h100, 4, 32'h66, 0, 5'b00100);
        t.chk_dst = 1'b0; t.mwe = 1; t.mrd = 6; t.mdat = 32'h66; vecs.push_back(t);

        // Reset state
        #12;
        chk("rst ctl", {24'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal, hazard, 1'b0}, 32'd0);
        chk("rst alu_op/dst", {23'd0, alu_op, ex_dst}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst store", ex_store_data, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("post-rst valid", {31'd0, ex_valid}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Load-use: lw r4 then add r5,r4,r1
        drive(it_i(6'h23, 1, 4, 16'h0000), 32'h200, 0);
        step();
        drive(rt_i(4, 1, 5, 6'h20), 32'hDEAD, 3);
        #1 chk("lu hazard", {31'd0, hazard}, 32'd1);
        step();
        chk("lu bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu hazard clr", {31'd0, hazard}, 32'd0);
        step();
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h777;
        #1;
        chk("lu issue valid", {31'd0, ex_valid}, 32'd1);
        chk("lu alu_a fwd", alu_a, 32'h777);
        chk("lu alu_b", alu_b, 32'd3);
        chk("lu dst", {27'd0, ex_dst}, 32'd5);
        clear_fwd();

        // Load-use while stalled: hazard visible, bubble waits for stall release
        drive(it_i(6'h23, 1, 4, 16'h0000), 32'h200, 0);
        step();
        drive(rt_i(4, 1, 5, 6'h20), 32'hDEAD, 3);
        stall = 1'b1;
        #1 chk("lus hazard", {31'd0, hazard}, 32'd1);
        step();
        chk("lus lw held", {30'd0, ex_valid, ex_mem_read}, 32'd3);
        chk("lus hazard still", {31'd0, hazard}, 32'd1);
        stall = 1'b0;
        step();
        chk("lus bubble", {31'd0, ex_valid}, 32'd0);
        step();
        chk("lus issue", {31'd0, ex_valid}, 32'd1);
        chk("lus alu_a", alu_a, 32'hDEAD);

        // Flush and hazard together: flush wins, no extra bubble afterwards
        drive(it_i(6'h23, 1, 4, 16'h0000), 32'h200, 0);
        step();
        drive(rt_i(4, 1, 5, 6'h20), 32'hDEAD, 3);
        flush = 1'b1;
        #1 chk("fh hazard", {31'd0, hazard}, 32'd1);
        step();
        flush = 1'b0;
        chk("fh flushed", {31'd0, ex_valid}, 32'd0);
        chk("fh hazard clr", {31'd0, hazard}, 32'd0);
        step();
        chk("fh add issue", {26'd0, ex_valid, ex_dst}, {26'd0, 1'b1, 5'd5});

        // Stall for 3 cycles, forwarding tracked while stalled, then flush during stall
        drive(rt_i(1, 2, 3, 6'h20), 5, 7);
        step();
        drive(rt_i(8, 9, 10, 6'h22), 1, 2);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d op/dst", c), {23'd0, alu_op, ex_dst}, {23'd0, 4'b0000, 5'd3});
            chk($sformatf("stall%0d alu_a", c), alu_a, 32'd5);
        end
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd1; fwd_wb_data = 32'h42;
        #1 chk("stall fwd track", alu_a, 32'h42);
        clear_fwd();
        flush = 1'b1;
        step();
        chk("stall+flush", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0; stall = 1'b0;
        step();
        chk("after stall", {22'd0, ex_valid, alu_op, ex_dst}, {22'd0, 1'b1, 4'b0010, 5'd10});

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 chk("async rst", {26'd0, ex_valid, ex_dst}, 32'd0);
        rst_n = 1'b1;
        id_valid = 1'b0;
        step();

        if (exp_q.size() != 0) begin
            nvec++; nfail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage sitting directly upstream of the ALU. It captures a decoded instruction and its register-file operands each cycle, generates the 4-bit AluOp, and presents the final ALU operands. The operands come from an immediate mux and EX/MEM and MEM/WB forwarding. It also detects load-use hazards, inserts bubbles, and honours pipeline stall and flush.

## Interface
- FWD_EN, 1: 1 enables operand forwarding; 0 always uses the captured register-file data.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_instr  in  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0]
- id_rs_data, id_rt_data  in  32 each  register-file read data
- stall  in  1  downstream stall; hold all EX registers
- flush  in  1  kill the instruction entering EX
- fwd_mem_we, fwd_mem_rd, fwd_mem_data  in  1/5/32  EX/MEM writeback: enable, register, value
- fwd_wb_we, fwd_wb_rd, fwd_wb_data  in  1/5/32  MEM/WB writeback: enable, register, value
- hazard  out  1  load-use detected (combinational); decode must hold its slot
- alu_a, alu_b  out  32 each  ALU operands (combinational from EX registers and forwarding)
- alu_op  out  4  registered AluOp
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  out  1 each  registered controls
- ex_dst  out  5  registered destination register
- ex_store_data  out  32  forwarded rt value, for sw

## Operation
AluOp encoding:
- add 0000, sub 0010, slt 1010
- and 0100, or 0101, xor 0110, nor 0111

R-type (opcode 0x00), by funct:
- 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt
- Operands: b = rt value; dst = rd; reg_write = 1

I-type, by opcode:
- 0x08/0x09 add; 0x0A slt. Immediate sign-extended; dst = rt; reg_write = 1.
- 0x0C and; 0x0D or; 0x0E xor. Immediate zero-extended; dst = rt; reg_write = 1.
- 0x23 lw: add, sign-extended immediate, mem_read = 1, dst = rt, reg_write = 1.
- 0x2B sw: add, sign-extended immediate, mem_write = 1, reg_write = 0.
- 0x04 beq: sub, b = rt value, branch = 1, reg_write = 0.

Illegal and degenerate cases:
- Any other opcode/funct is illegal: all controls 0 except ex_valid = 1 and ex_illegal = 1.
- dst = 0 forces reg_write = 0.

Forwarding, applied separately to the rs and rt values:
- Source register 0 is never forwarded; it reads id data as given.
- EX/MEM is used if fwd_mem_we and fwd_mem_rd matches the register.
- Otherwise MEM/WB is used if fwd_wb_we and fwd_wb_rd matches.
- Otherwise the captured register-file data is used.
- The forwarded rt value drives alu_b (R-type, beq) and ex_store_data.

Load-use hazard:
- hazard = ex_valid & ex_mem_read & id_valid & ex_dst≠0 & (ex_dst==rs | (uses_rt & ex_dst==rt)).
- uses_rt holds for R-type, sw and beq.

## Timing
- Reset (asynchronous on rst_n low): every registered output is 0. alu_op = 0000, ex_dst = 0, and captured data is 0, so alu_a = alu_b = 0 unless forwarding matches.

Per-edge priority:
1. flush: ex_valid and every control go to 0; data registers don't-care.
2. stall: hold all registers.
3. hazard: insert a bubble; ex_valid and controls go to 0.
4. Otherwise capture the decode slot. If id_valid = 0, controls go to 0.

- Latency: 1 cycle from decode to alu_op and controls.
- Forwarding muxes are combinational and reflect fwd_* in the same cycle.
- During stall the forwarding muxes keep tracking fwd_*, so a value written back while stalled is still picked up.
- hazard is reported even when stall = 1; the bubble is inserted on the first edge without stall or flush.
- flush and hazard in the same cycle: flush wins; hazard re-evaluates next cycle.

## Test plan
- Reset then release: all outputs 0. Then R-type add (funct 0x20) with rs_data=5, rt_data=7 → next cycle alu_op=0000, alu_a=5, alu_b=7, ex_dst=rd, ex_reg_write=1.
- Immediate extension: andi with imm 0xFFFF → alu_b=0x0000FFFF, alu_op=0100. slti with imm 0xFFFF → alu_b=0xFFFFFFFF, alu_op=1010.
- Forwarding priority: EX writes r3=0x11 while MEM/WB writes r3=0x22, next instruction reads r3 → alu_a=0x11. Same case with rs=0 → alu_a=id data, no forwarding.
- Load-use: lw r4 followed by add r5,r4,r1 → hazard=1 for one cycle, one bubble (ex_valid=0), then the add issues with r4 forwarded from EX/MEM.
- stall=1 for 3 cycles: EX registers frozen. flush together with stall → ex_valid=0 on that edge.
- Illegal opcode 0x3F → ex_valid=1, ex_illegal=1, reg_write/mem_read/mem_write/branch all 0.
